// File: rtl/arbiter_bus_controller_if.sv
// Shared memory port between the transaction controller (master) and the memory (slave).
interface arbiter_bus_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (output mem_req, mem_wr, mem_addr, mem_wr_data,
                  input  mem_ack, mem_rd_data);
  modport slave  (input  mem_req, mem_wr, mem_addr, mem_wr_data,
                  output mem_ack, mem_rd_data);
endinterface

// File: rtl/arbiter_bus_controller.sv
// Runs one shared-memory transaction per grant and holds the round-robin arbiter while busy.
// Optional request timeout abort enabled by defining ARB_TIMEOUT_EN.
module arbiter_bus_controller #(
  parameter int NUM_CLIENTS    = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            grants,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wr_data,
  input  logic [NUM_CLIENTS-1:0]            client_wr_en,
  output logic                              hold,
  output logic                              busy,
  output logic [NUM_CLIENTS-1:0]            client_done,
  output logic [NUM_CLIENTS-1:0]            client_err,
  output logic [DATA_WIDTH-1:0]             client_rd_data,
  arbiter_bus_controller_if.master          mem
);
  localparam int IDXW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       sel_idx, gidx;
  logic                  timeout;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] wdat_arr [NUM_CLIENTS];

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    assign addr_arr[i] = client_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_arr[i] = client_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest set bit wins if the arbiter ever hands us more than one grant.
  always_comb begin
    gidx = '0;
    for (int i = NUM_CLIENTS-1; i >= 0; i--)
      if (grants[i]) gidx = IDXW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|grants) state_d = REQ;
      REQ:     if (mem.mem_ack || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hold = (state_q != IDLE);
  assign busy = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_idx         <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_wr      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wr_data <= '0;
      client_rd_data  <= '0;
      client_done     <= '0;
    end else begin
      client_done <= '0;
      case (state_q)
        IDLE: if (|grants) begin
          sel_idx         <= gidx;
          mem.mem_addr    <= addr_arr[gidx];
          mem.mem_wr_data <= wdat_arr[gidx];
          mem.mem_wr      <= client_wr_en[gidx];
          mem.mem_req     <= 1'b1;
        end
        REQ: if (mem.mem_ack) begin
          // Write acks also return whatever the memory drives; the client ignores it.
          client_rd_data       <= mem.mem_rd_data;
          mem.mem_req          <= 1'b0;
          client_done[sel_idx] <= 1'b1;
        end else if (timeout) begin
          client_rd_data       <= '0;
          mem.mem_req          <= 1'b0;
          client_done[sel_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES+1);

  logic [CNTW-1:0] to_cnt;

  // Count holds the number of ack-less REQ cycles already completed.
  assign timeout = (state_q == REQ) && !mem.mem_ack &&
                   (to_cnt == CNTW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt     <= '0;
      client_err <= '0;
    end else begin
      client_err <= '0;
      if (state_q == IDLE)
        to_cnt <= '0;
      else if (state_q == REQ && !mem.mem_ack)
        to_cnt <= to_cnt + 1'b1;
      if (timeout)
        client_err[sel_idx] <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign client_err         = '0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_arbiter_bus_controller.sv
// Directed self-checking bench for arbiter_bus_controller.
module tb_arbiter_bus_controller;
  localparam int NC = 8, AW = 32, DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   grants;
  logic [NC*AW-1:0] client_addr;
  logic [NC*DW-1:0] client_wr_data;
  logic [NC-1:0]   client_wr_en;
  logic            hold, busy;
  logic [NC-1:0]   client_done, client_err;
  logic [DW-1:0]   client_rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  arbiter_bus_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) membus ();

  arbiter_bus_controller #(
    .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .grants(grants), .client_addr(client_addr),
    .client_wr_data(client_wr_data), .client_wr_en(client_wr_en),
    .hold(hold), .busy(busy), .client_done(client_done), .client_err(client_err),
    .client_rd_data(client_rd_data), .mem(membus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int c);
    return AW'(32'h0000_0100 * c + 32'h10);
  endfunction

  initial begin
    rst = 1'b1;
    grants = '0;
    client_addr = '0;
    client_wr_data = '0;
    client_wr_en = '0;
    membus.mem_ack = 1'b0;
    membus.mem_rd_data = '0;
    for (int c = 0; c < NC; c++) begin
      client_addr[c*AW +: AW]    = addr_of(c);
      client_wr_data[c*DW +: DW] = 64'hC0DE_0000 + 64'(c);
    end
    client_addr[2*AW +: AW] = 32'h1000;
    step(); step();
    chk("rst_mem_req", 64'(membus.mem_req), 0);
    chk("rst_hold", 64'(hold), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(client_done), 0);
    chk("rst_err", 64'(client_err), 0);
    chk("rst_rd", client_rd_data, 0);
    chk("rst_addr", 64'(membus.mem_addr), 0);
    rst = 1'b0;

    // single read from client 2, ack in the third REQ cycle
    grants = 8'b0000_0100;
    step();
    chk("rd_req", 64'(membus.mem_req), 1);
    chk("rd_addr", 64'(membus.mem_addr), 64'h1000);
    chk("rd_wr", 64'(membus.mem_wr), 0);
    chk("rd_hold", 64'(hold), 1);
    grants = '0;
    step();
    chk("rd_req_c2", 64'(membus.mem_req), 1);
    step();
    membus.mem_ack = 1'b1;
    membus.mem_rd_data = 64'hDEAD_BEEF;
    step();
    membus.mem_ack = 1'b0;
    membus.mem_rd_data = '0;
    chk("rd_done", 64'(client_done), 64'b0000_0100);
    chk("rd_data", client_rd_data, 64'hDEAD_BEEF);
    chk("rd_req_drop", 64'(membus.mem_req), 0);
    chk("rd_busy_resp", 64'(busy), 1);
    step();
    chk("rd_done_once", 64'(client_done), 0);
    chk("rd_idle_hold", 64'(hold), 0);

    // back-to-back chain 4,3,2,4 with ack in first REQ cycle; next grant shown during RESP
    client_addr[2*AW +: AW] = addr_of(2);
    begin
      int seq [4] = '{4, 3, 2, 4};
      grants = NC'(1) << seq[0];
      for (int n = 0; n < 4; n++) begin
        step();
        chk("rr_req", 64'(membus.mem_req), 1);
        chk("rr_addr", 64'(membus.mem_addr), 64'(addr_of(seq[n])));
        chk("rr_hold_req", 64'(hold), 1);
        membus.mem_ack = 1'b1;
        membus.mem_rd_data = 64'(seq[n]) + 64'hA0;
        step();
        membus.mem_ack = 1'b0;
        chk("rr_done", 64'(client_done), 64'(NC'(1) << seq[n]));
        chk("rr_rd", client_rd_data, 64'(seq[n]) + 64'hA0);
        chk("rr_hold_resp", 64'(hold), 1);
        grants = (n < 3) ? (NC'(1) << seq[n+1]) : '0;
        step();
        chk("rr_idle", 64'(hold), 0);
        chk("rr_addr_kept", 64'(membus.mem_addr), 64'(addr_of(seq[n])));
      end
    end

    // write from client 7, inputs change mid-REQ but memory outputs stay put
    client_wr_en[7] = 1'b1;
    client_wr_data[7*DW +: DW] = 64'h55AA;
    grants = 8'b1000_0000;
    step();
    grants = 8'b0000_0001;
    client_wr_data[7*DW +: DW] = 64'hFFFF;
    chk("wr_mem_wr", 64'(membus.mem_wr), 1);
    chk("wr_data", membus.mem_wr_data, 64'h55AA);
    step();
    chk("wr_data_held", membus.mem_wr_data, 64'h55AA);
    chk("wr_addr_held", 64'(membus.mem_addr), 64'(addr_of(7)));
    membus.mem_ack = 1'b1;
    step();
    membus.mem_ack = 1'b0;
    grants = '0;
    chk("wr_done", 64'(client_done), 64'h80);
    step();
    client_wr_en[7] = 1'b0;

    // reset while in REQ
    grants = 8'b0010_0000;
    step();
    chk("rstm_req", 64'(membus.mem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstm_req_low", 64'(membus.mem_req), 0);
    chk("rstm_hold", 64'(hold), 0);
    chk("rstm_addr", 64'(membus.mem_addr), 0);
    chk("rstm_done", 64'(client_done), 0);
    grants = '0;
    membus.mem_ack = 1'b1;   // stray ack in IDLE
    step();
    membus.mem_ack = 1'b0;
    chk("stray_ack_hold", 64'(hold), 0);
    chk("stray_ack_done", 64'(client_done), 0);
    grants = 8'b0010_0000;
    step();
    chk("rstm_regrant", 64'(membus.mem_addr), 64'(addr_of(5)));
    grants = '0;
    membus.mem_ack = 1'b1;
    step();
    membus.mem_ack = 1'b0;
    chk("rstm_done2", 64'(client_done), 64'h20);
    step();

    // non-one-hot grants: lowest index wins
    grants = 8'b0001_0010;
    step();
    grants = '0;
    chk("multi_addr", 64'(membus.mem_addr), 64'(addr_of(1)));
    membus.mem_ack = 1'b1;
    step();
    membus.mem_ack = 1'b0;
    chk("multi_done", 64'(client_done), 64'h02);
    chk("multi_err", 64'(client_err), 0);
    step();

`ifdef ARB_TIMEOUT_EN
    // no ack: four REQ cycles then an error completion
    grants = 8'b0000_1000;
    step();
    grants = '0;
    for (int c = 0; c < 4; c++) begin
      chk("to_req_held", 64'(membus.mem_req), 1);
      if (c < 3) step();
    end
    step();
    chk("to_req_drop", 64'(membus.mem_req), 0);
    chk("to_done", 64'(client_done), 64'h08);
    chk("to_err", 64'(client_err), 64'h08);
    chk("to_rd_zero", client_rd_data, 0);
    step();
    chk("to_err_once", 64'(client_err), 0);
    // ack in the fourth REQ cycle beats the timeout
    grants = 8'b0000_1000;
    step();
    grants = '0;
    step(); step(); step();
    membus.mem_ack = 1'b1;
    membus.mem_rd_data = 64'hABC;
    step();
    membus.mem_ack = 1'b0;
    chk("to_ack_done", 64'(client_done), 64'h08);
    chk("to_ack_err", 64'(client_err), 0);
    chk("to_ack_rd", client_rd_data, 64'hABC);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
